// File: rtl/register_bank.sv
// -----------------------------------------------------------------------------
// register_bank
//   Storage stage of the CPU register file: sixteen N-bit architectural
//   registers R0..R15, exposed as one packed bus that feeds the 16:1 read-port
//   multiplexers (slice k drives mux input k).
//
//   Two write ports:
//     port 1 : ALU/load result
//     port 2 : base-register write-back
//   Port 1 wins on an address collision.
//
//   Reset values:
//     R13 (stack pointer)   : SP_INIT
//     R15 (program counter) : PC_INIT
//     all other registers   : 0
//
//   R15 advances by PC_STEP when pc_en_i is set. Any explicit write to R15
//   (a branch) overrides that increment. stall_i freezes every register.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active-high
//   stall_i   in   1      freeze all registers this cycle
//   pc_en_i   in   1      advance R15 by PC_STEP this cycle
//   we1_i     in   1      write enable, port 1
//   waddr1_i  in   4      write address, port 1
//   wdata1_i  in   N      write data, port 1
//   we2_i     in   1      write enable, port 2
//   waddr2_i  in   4      write address, port 2
//   wdata2_i  in   N      write data, port 2
//   regs_o    out  16*N   packed contents; R[k] = regs_o[k*N +: N]
//   pc_o      out  N      copy of R15 for fetch
// -----------------------------------------------------------------------------
module register_bank #(
  parameter int           N       = 32,
  parameter logic [N-1:0] SP_INIT = N'(32'h0000_1000),
  parameter logic [N-1:0] PC_INIT = N'(32'h0000_0000),
  parameter int           PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            pc_en_i,
  input  logic            we1_i,
  input  logic [3:0]      waddr1_i,
  input  logic [N-1:0]    wdata1_i,
  input  logic            we2_i,
  input  logic [3:0]      waddr2_i,
  input  logic [N-1:0]    wdata2_i,
  output logic [16*N-1:0] regs_o,
  output logic [N-1:0]    pc_o
);

  localparam int SP_IDX = 13;
  localparam int PC_IDX = 15;

  logic [N-1:0] regs_q [16];
  logic [N-1:0] regs_d [16];

  // Next-state logic.
  // The later assignments in this block override the earlier ones, which
  // gives the priority order: port 1 > port 2 > PC increment > hold.
  always_comb begin
    // NOTE: default every element to its held value first so that no path
    // leaves regs_d unassigned; otherwise a latch is inferred.
    regs_d = regs_q;
    if (!stall_i) begin
      if (pc_en_i) regs_d[PC_IDX] = regs_q[PC_IDX] + N'(PC_STEP);
      if (we2_i)   regs_d[waddr2_i] = wdata2_i;
      if (we1_i)   regs_d[waddr1_i] = wdata1_i;
    end
  end

  // NOTE: every element of this array is reset. It is built from flops, not
  // RAM, because all sixteen entries are read in parallel on regs_o. SP and
  // PC need defined values at reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        // NOTE: use non-blocking assignments for state so that every register
        // samples its pre-edge value.
        regs_q[k] <= '0;
      end
      regs_q[SP_IDX] <= SP_INIT;
      regs_q[PC_IDX] <= PC_INIT;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Outputs come straight from the stored values. There is no write bypass.
  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign regs_o[g*N +: N] = regs_q[g];
  end

  assign pc_o = regs_q[PC_IDX];

endmodule

// File: tb/tb_register_bank.sv
// -----------------------------------------------------------------------------
// tb_register_bank
//   Directed test of register_bank.
//
//   A behavioural model of the sixteen architectural registers is compared
//   against every output slice and against pc_o on each falling edge.
//   Hand-computed literal expectations at key points pin down the model
//   itself.
// -----------------------------------------------------------------------------
module tb_register_bank;

  localparam int N = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall_i = 1'b0;
  logic            pc_en_i = 1'b0;
  logic            we1_i = 1'b0;
  logic [3:0]      waddr1_i = '0;
  logic [N-1:0]    wdata1_i = '0;
  logic            we2_i = 1'b0;
  logic [3:0]      waddr2_i = '0;
  logic [N-1:0]    wdata2_i = '0;
  logic [16*N-1:0] regs_o;
  logic [N-1:0]    pc_o;

  int tests_run = 0;
  int tests_failed = 0;
  bit cmp_en = 1'b0;

  logic [N-1:0] model [16];

  register_bank #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall_i  (stall_i),
    .pc_en_i  (pc_en_i),
    .we1_i    (we1_i),
    .waddr1_i (waddr1_i),
    .wdata1_i (wdata1_i),
    .we2_i    (we2_i),
    .waddr2_i (waddr2_i),
    .wdata2_i (wdata2_i),
    .regs_o   (regs_o),
    .pc_o     (pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] r(input int k);
    return regs_o[k*N +: N];
  endfunction

  // Architectural model: per-register rules written out one by one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        model[k] <= (k == 13) ? 32'h0000_1000 : 32'h0;
      end
    end else if (!stall_i) begin
      for (int k = 0; k < 16; k++) begin
        if (we1_i && int'(waddr1_i) == k)      model[k] <= wdata1_i;
        else if (we2_i && int'(waddr2_i) == k) model[k] <= wdata2_i;
        else if (k == 15 && pc_en_i)           model[k] <= model[k] + 32'd4;
      end
    end
  end

  // Compare process: every falling edge, all slices and pc_o against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 16; k++) begin
        check($sformatf("model_R%0d", k), r(k), model[k]);
      end
      check("model_pc_o", pc_o, model[15]);
    end
  end

  // Drive one cycle of inputs on the falling edge, then wait for the
  // rising edge and settle.
  task automatic step(input bit st, input bit pe,
                      input bit w1, input int a1, input logic [N-1:0] d1,
                      input bit w2, input int a2, input logic [N-1:0] d2);
    @(negedge clk);
    stall_i  = st;
    pc_en_i  = pe;
    we1_i    = w1;
    waddr1_i = 4'(a1);
    wdata1_i = d1;
    we2_i    = w2;
    waddr2_i = 4'(a2);
    wdata2_i = d2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Power-on reset.
    #12;
    check("por_R13", r(13), 32'h0000_1000);
    check("por_R15", r(15), 32'h0);
    check("por_R0", r(0), 32'h0);
    #5 rst = 1'b0;
    cmp_en = 1'b1;

    // Single write on port 1.
    step(0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 0);
    check("single_R3", r(3), 32'hDEADBEEF);
    check("single_R2", r(2), 32'h0);
    check("single_R4", r(4), 32'h0);

    // Dual write to different registers, then a collision on R4.
    step(0, 0, 1, 1, 32'd5, 1, 2, 32'd7);
    check("dual_R1", r(1), 32'd5);
    check("dual_R2", r(2), 32'd7);
    step(0, 0, 1, 4, 32'd11, 1, 4, 32'd22);
    check("collide_R4", r(4), 32'd11);

    // PC advance.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("pc_4", pc_o, 32'd4);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("pc_8", pc_o, 32'd8);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("pc_12", r(15), 32'd12);

    // A branch write on port 2 overrides the increment.
    step(0, 1, 0, 0, 0, 1, 15, 32'h100);
    check("branch_pc", pc_o, 32'h100);

    // PC wrap-around.
    step(0, 0, 1, 15, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("pc_wrap", pc_o, 32'h0);

    // Stall freezes everything; releasing it lets the same inputs commit.
    step(1, 1, 1, 5, 32'd9, 0, 0, 0);
    check("stall_R5", r(5), 32'h0);
    check("stall_pc", pc_o, 32'h0);
    step(0, 1, 1, 5, 32'd9, 0, 0, 0);
    check("unstall_R5", r(5), 32'd9);
    check("unstall_pc", pc_o, 32'd4);

    // Asynchronous reset mid-cycle, with a write pending.
    @(negedge clk);
    we1_i    = 1'b1;
    waddr1_i = 4'd3;
    wdata1_i = 32'h1234_5678;
    #2 rst = 1'b1;
    #1;
    check("arst_R3", r(3), 32'h0);
    check("arst_R5", r(5), 32'h0);
    check("arst_R13", r(13), 32'h0000_1000);
    check("arst_pc", pc_o, 32'h0);
    @(posedge clk);
    #1;
    check("arst_hold_R3", r(3), 32'h0);
    we1_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;

    // Sweep: write k*3 into every register.
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 1, k, N'(k * 3), 0, 0, 0);
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sweep_R%0d", k), r(k), N'(k * 3));
    end
    check("sweep_pc", pc_o, 32'd45);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
